lock_code_serializer: RTL and testbench

Upstream feeder for the door-lock sequence FSM: accepts a parallel code word over a valid/ready handshake and emits it MSB-first as the FSM's one-bit serial input. Each bit is held for a programmable number of clocks. Every frame is followed by a guard gap of zeros. A one-entry holding buffer lets the next code be queued while the current one shifts.

---
 rtl/door_lock_pkg.sv | 20 ++
 rtl/lock_code_buffer.sv | 50 +++++
 rtl/lock_code_serializer.sv | 118 +++++++++++
 tb/tb_lock_code_serializer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/door_lock_pkg.sv
// Shared types and defaults for the door-lock datapath.
// Used by the code serializer and the lock FSM.
package door_lock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int LOCK_CODE_W     = 8;
  localparam int LOCK_BIT_CYCLES = 4;
  localparam int LOCK_IDLE_BITS  = 2;

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/lock_code_buffer.sv
// One-entry holding register in front of the serializer.
// Accept wins over pop so a same-edge refill is never lost.
module lock_code_buffer
  import door_lock_pkg::*;
#(
  parameter int W = LOCK_CODE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_full,
  input  logic         pop
);

  logic [W-1:0] data_q, data_d;
  logic         full_q, full_d;
  logic         accept;

  assign in_ready = !full_q;
  assign accept   = in_valid && in_ready;
  assign out_data = data_q;
  assign out_full = full_q;

  // Next-state: capture on accept, drop the flag on pop.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (accept) begin
      data_d = in_data;
      full_d = 1'b1;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/lock_code_serializer.sv
// Parallel code word to MSB-first serial stream for the lock FSM.
// Each bit held BIT_CYCLES clocks; each frame ends in a zero gap.
module lock_code_serializer
  import door_lock_pkg::*;
#(
  parameter int CODE_W     = LOCK_CODE_W,
  parameter int BIT_CYCLES = LOCK_BIT_CYCLES,
  parameter int IDLE_BITS  = LOCK_IDLE_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  output logic              x_out,
  output logic              bit_strobe,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy
);

  localparam int GAP_LEN = IDLE_BITS * BIT_CYCLES;
  localparam int CYC_W   = clog2_min1(BIT_CYCLES);
  localparam int BIT_W   = $clog2(CODE_W);
  localparam int GAP_W   = clog2_min1(GAP_LEN);

  localparam logic [CYC_W-1:0] CYC_LAST =
    CYC_W'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST =
    BIT_W'(CODE_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'(GAP_LEN - 1);

  state_e            state_q;
  logic [CODE_W-1:0] shift_q;
  logic [BIT_W-1:0]  bit_q;
  logic [CYC_W-1:0]  cyc_q;
  logic [GAP_W-1:0]  gap_q;

  logic [CODE_W-1:0] buf_data;
  logic              buf_full;
  logic              gap_last;
  logic              load;

  lock_code_buffer #(
    .W (CODE_W)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .in_data  (code_in),
    .in_valid (code_valid),
    .in_ready (code_ready),
    .out_data (buf_data),
    .out_full (buf_full),
    .pop      (load)
  );

  assign gap_last = (gap_q == GAP_LAST);

  // A new frame starts from IDLE or straight out of the gap.
  assign load = buf_full &&
    ((state_q == IDLE) ||
     (state_q == GAP && gap_last));

  // Sequencer: load, shift each bit, then count the gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      gap_q   <= '0;
    end else if (load) begin
      state_q <= SHIFT;
      shift_q <= buf_data;
      bit_q   <= BIT_LAST;
      cyc_q   <= '0;
      gap_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        SHIFT: begin
          if (cyc_q == CYC_LAST) begin
            cyc_q   <= '0;
            shift_q <= shift_q << 1;
            if (bit_q == '0) begin
              state_q <= GAP;
              gap_q   <= '0;
            end else begin
              bit_q <= bit_q - BIT_W'(1);
            end
          end else begin
            cyc_q <= cyc_q + CYC_W'(1);
          end
        end
        GAP: begin
          if (gap_last) begin
            state_q <= IDLE;
            gap_q   <= '0;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = (state_q != IDLE);
  assign x_out      = (state_q == SHIFT) &&
                      shift_q[CODE_W-1];
  assign bit_strobe = (state_q == SHIFT) &&
                      (cyc_q == '0);
  assign frame_start = bit_strobe &&
                       (bit_q == BIT_LAST);
  assign frame_done = (state_q == GAP) && gap_last;

endmodule

// File: tb/tb_lock_code_serializer.sv
// Bench for lock_code_serializer: vector table, scoreboard,
// back-to-back, reset mid-frame, and a 1-clock-per-bit build.
module tb_lock_code_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] code_in = '0;
  logic       code_valid = 1'b0;
  logic       code_ready, x_out, bit_strobe;
  logic       frame_start, frame_done, busy;

  logic [7:0] code8 = '0;
  logic       valid8 = 1'b0;
  logic       ready8, x8, strobe8, fs8, fd8, busy8;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;

  always #5 clk = ~clk;

  lock_code_serializer #(
    .CODE_W(4), .BIT_CYCLES(2), .IDLE_BITS(1)
  ) dut (
    .clk(clk), .reset(reset),
    .code_in(code_in), .code_valid(code_valid),
    .code_ready(code_ready), .x_out(x_out),
    .bit_strobe(bit_strobe), .frame_start(frame_start),
    .frame_done(frame_done), .busy(busy)
  );

  lock_code_serializer #(
    .CODE_W(8), .BIT_CYCLES(1), .IDLE_BITS(2)
  ) dut8 (
    .clk(clk), .reset(reset),
    .code_in(code8), .code_valid(valid8),
    .code_ready(ready8), .x_out(x8),
    .bit_strobe(strobe8), .frame_start(fs8),
    .frame_done(fd8), .busy(busy8)
  );

  task automatic chk(input string name,
                     input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  typedef struct {
    logic b;
    logic first;
  } sb_t;
  sb_t sb[$];

  // Scoreboard push: expected bit stream of every accepted word.
  always @(posedge clk) begin
    if (!reset && code_valid && code_ready) begin
      acc_cnt++;
      for (int i = 3; i >= 0; i--) begin
        sb_t e;
        e.b = code_in[i];
        e.first = (i == 3);
        sb.push_back(e);
      end
    end
  end

  // Scoreboard pop: compare each data bit at its strobe.
  always @(negedge clk) begin
    if (!reset && bit_strobe) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_bit", 1, 0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb_bit", int'(x_out), int'(e.b));
        chk("sb_fstart", int'(frame_start),
            int'(e.first));
      end
    end
  end

  typedef struct {
    logic x, st, fs, fd, bz, rdy;
  } vec_t;
  vec_t tbl[12];

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    code_valid = 1'b0;
    valid8 = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic start_frame(input logic [3:0] c);
    @(negedge clk);
    code_in = c;
    code_valid = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    int fs_q[$];
    int fd_q[$];
    int want, busy_n, fd_n, fd_at;
    logic [3:0] fx;
    logic [7:0] v8;

    // Reset state.
    #1;
    chk("rst_ready", int'(code_ready), 1);
    chk("rst_x", int'(x_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_strobe", int'(bit_strobe), 0);
    chk("rst_fstart", int'(frame_start), 0);
    chk("rst_fdone", int'(frame_done), 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;

    // Single frame 1011, per-cycle vector table.
    fx = 4'b1011;
    for (int k = 0; k < 12; k++) begin
      tbl[k].x   = 1'b0;
      tbl[k].st  = (k >= 1 && k <= 7 && k % 2 == 1);
      tbl[k].fs  = (k == 1);
      tbl[k].fd  = (k == 10);
      tbl[k].bz  = (k >= 1 && k <= 10);
      tbl[k].rdy = (k != 0);
      if (k >= 1 && k <= 8)
        tbl[k].x = fx[3 - (k - 1) / 2];
    end
    start_frame(fx);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("t%0d_x", k),
          int'(x_out), int'(tbl[k].x));
      chk($sformatf("t%0d_strobe", k),
          int'(bit_strobe), int'(tbl[k].st));
      chk($sformatf("t%0d_fstart", k),
          int'(frame_start), int'(tbl[k].fs));
      chk($sformatf("t%0d_fdone", k),
          int'(frame_done), int'(tbl[k].fd));
      chk($sformatf("t%0d_busy", k),
          int'(busy), int'(tbl[k].bz));
      chk($sformatf("t%0d_ready", k),
          int'(code_ready), int'(tbl[k].rdy));
      if (k == 0) code_valid = 1'b0;
    end
    chk("t_sb_empty", sb.size(), 0);

    // Back-to-back: A, then B and C queued behind it.
    do_reset();
    acc_cnt = 0;
    start_frame(4'b1011);
    want = 0;
    busy_n = 0;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      if (frame_start) fs_q.push_back(k);
      if (frame_done) fd_q.push_back(k);
      if (busy) busy_n++;
      if (k >= 3 && k <= 9)
        chk($sformatf("b2b_ready_c%0d", k),
            int'(code_ready), 0);
      if (k == 31) chk("b2b_idle", int'(busy), 0);
      if (k == 0) begin
        code_valid = 1'b0;
      end else if (k == 1) begin
        code_in = 4'b0110;
        code_valid = 1'b1;
        want = 2;
      end else if (code_valid && acc_cnt >= want) begin
        if (want == 2) begin
          code_in = 4'b1001;
          want = 3;
        end else begin
          code_valid = 1'b0;
        end
      end
      if (k == 12) chk("b2b_accepted", acc_cnt, 3);
    end
    chk("b2b_fs_count", fs_q.size(), 3);
    chk("b2b_fd_count", fd_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < fs_q.size())
        chk($sformatf("b2b_fs%0d", i), fs_q[i],
            1 + 10 * i);
      if (i < fd_q.size())
        chk($sformatf("b2b_fd%0d", i), fd_q[i],
            10 + 10 * i);
    end
    chk("b2b_busy_cycles", busy_n, 30);
    chk("b2b_sb_empty", sb.size(), 0);

    // Reset in cycle 4 of a frame with a word buffered.
    do_reset();
    start_frame(4'b1101);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) code_valid = 1'b0;
      if (k == 1) begin
        code_in = 4'b0011;
        code_valid = 1'b1;
      end
      if (k == 2) code_valid = 1'b0;
    end
    chk("mid_x_before", int'(x_out), 1);
    chk("mid_busy_before", int'(busy), 1);
    chk("mid_ready_before", int'(code_ready), 0);
    #2 reset = 1'b1;
    #1;
    chk("mid_x_async", int'(x_out), 0);
    chk("mid_busy_async", int'(busy), 0);
    chk("mid_ready_async", int'(code_ready), 1);
    chk("mid_fdone_async", int'(frame_done), 0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    fd_n = 0;
    busy_n = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (frame_done) fd_n++;
      if (busy) busy_n++;
    end
    chk("mid_no_fdone", fd_n, 0);
    chk("mid_discarded", busy_n, 0);
    start_frame(4'b0101);
    fd_at = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) code_valid = 1'b0;
      if (frame_done && fd_at < 0) fd_at = k;
    end
    chk("mid_fresh_fdone", fd_at, 10);
    chk("mid_sb_empty", sb.size(), 0);

    // CODE_W=8, one clock per bit, two-clock gap.
    v8 = 8'hA5;
    @(negedge clk);
    code8 = v8;
    valid8 = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) valid8 = 1'b0;
      chk($sformatf("w8_c%0d_x", k), int'(x8),
          (k >= 1 && k <= 8) ? int'(v8[8 - k]) : 0);
      chk($sformatf("w8_c%0d_strobe", k),
          int'(strobe8), int'(k >= 1 && k <= 8));
      chk($sformatf("w8_c%0d_fstart", k),
          int'(fs8), int'(k == 1));
      chk($sformatf("w8_c%0d_fdone", k),
          int'(fd8), int'(k == 10));
      chk($sformatf("w8_c%0d_busy", k),
          int'(busy8), int'(k >= 1 && k <= 10));
    end
    chk("w8_ready_end", int'(ready8), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
